// File: rtl/osc_noise.sv
// osc_noise: 32-bit Galois LFSR noise source with a sample-and-hold rate
// reducer ("crush"); the noise sample only refreshes every L enabled clocks.
module osc_noise #(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [16:0] sample,
    input  logic [16:0] crush
);

    localparam logic [31:0] TAPS     = 32'h8020_0003;
    // An all-zero seed would lock the LFSR, so it falls back to 1.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;

    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        logic [31:0] nxt;
        nxt = cur >> 5'd1;
        if (cur[0]) begin
            nxt = nxt ^ TAPS;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

    logic [31:0] lfsr_r;
    logic [16:0] cnt_r;
    logic [16:0] hold_len_s;
    logic        hold_done_s;
    logic [31:0] lfsr_next_s;

    // Hold-length decode, end-of-hold detect and next LFSR value (with lockup guard).
    always_comb begin
        hold_len_s  = 17'd1;
        hold_done_s = 1'b0;
        lfsr_next_s = SEED_EFF;
        if (crush == 17'd0) begin
            hold_len_s = 17'd1;
        end else begin
            hold_len_s = crush;
        end
        // >= rather than == so that shrinking crush mid-hold releases on the next enabled edge.
        hold_done_s = (cnt_r >= (hold_len_s - 17'd1));
        if (lfsr_r == 32'h0000_0000) begin
            lfsr_next_s = SEED_EFF;
        end else begin
            lfsr_next_s = lfsr_step(lfsr_r);
        end
    end

    // State and registered sample; reset wins over enable, disabled edges hold everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= SEED_EFF;
            cnt_r  <= 17'd0;
            sample <= 17'd0;
        end else if (en) begin
            if (hold_done_s) begin
                cnt_r  <= 17'd0;
                lfsr_r <= lfsr_next_s;
                sample <= lfsr_next_s[16:0];
            end else begin
                cnt_r  <= cnt_r + 17'd1;
            end
        end else begin
            cnt_r  <= cnt_r;
            lfsr_r <= lfsr_r;
            sample <= sample;
        end
    end

endmodule

// File: tb/tb_osc_noise.sv
// Scoreboard bench for osc_noise: a behavioural model predicts the sample after
// every clock edge; a separate monitor compares the DUT against the queue.
module tb_osc_noise;

    localparam logic [31:0] SEED = 32'h0000_0001;
    localparam logic [31:0] POLY = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [16:0] crush = 17'd0;
    logic [16:0] sample;

    osc_noise #(.SEED(SEED)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .sample (sample),
        .crush  (crush)
    );

    always #5 clk = ~clk;

    logic [16:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    // Model state: current noise word, enabled edges spent in the current hold, shown sample.
    logic [31:0] m_lfsr;
    int          m_run;
    logic [16:0] m_smp;

    function automatic logic [31:0] noise_next(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ POLY;
        return n;
    endfunction

    // Apply one clock's inputs and push the sample expected right after that edge.
    task automatic drive(input logic r, input logic e, input int c);
        int len;
        @(negedge clk);
        rst   = r;
        en    = e;
        crush = c[16:0];
        len   = (c == 0) ? 1 : c;
        if (r) begin
            m_lfsr = SEED;
            m_run  = 0;
            m_smp  = 17'd0;
        end else if (e) begin
            m_run = m_run + 1;
            if (m_run >= len) begin
                m_lfsr = noise_next(m_lfsr);
                m_smp  = m_lfsr[16:0];
                m_run  = 0;
            end
        end
        exp_q.push_back(m_smp);
    endtask

    task automatic drive_n(input logic r, input logic e, input int c, input int n);
        for (int i = 0; i < n; i++) drive(r, e, c);
    endtask

    // Monitor: after every rising edge, compare the DUT sample with the oldest prediction.
    initial begin : monitor
        logic [16:0] exp_v;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp_v  = exp_q.pop_front();
                checks = checks + 1;
                if (sample !== exp_v) begin
                    errors = errors + 1;
                    $display("FAIL sample check#%0d t=%0t got=%h exp=%h", checks, $time, sample, exp_v);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int cur_c;
        logic r, e;

        // Reset with en high: reset must win, sample 0.
        drive(1'b1, 1'b1, 10);
        // crush=10: changes at enabled edges 10, 20, 30.
        drive_n(1'b0, 1'b1, 10, 30);

        // crush=0 and crush=1: update on every enabled edge.
        drive(1'b1, 1'b0, 0);
        drive_n(1'b0, 1'b1, 0, 3);
        drive(1'b1, 1'b0, 1);
        drive_n(1'b0, 1'b1, 1, 3);

        // Enable dropped mid-hold freezes the count.
        drive(1'b1, 1'b0, 10);
        drive_n(1'b0, 1'b1, 10, 4);
        drive_n(1'b0, 1'b0, 10, 5);
        drive_n(1'b0, 1'b1, 10, 16);

        // Lowering crush below the current count forces the next enabled update.
        drive(1'b1, 1'b0, 10);
        drive_n(1'b0, 1'b1, 10, 7);
        drive_n(1'b0, 1'b1, 4, 9);

        // Raising crush extends the current hold.
        drive(1'b1, 1'b0, 4);
        drive_n(1'b0, 1'b1, 4, 2);
        drive_n(1'b0, 1'b1, 12, 14);

        // Reset mid-hold discards the partial count and restarts from the seed.
        drive(1'b1, 1'b0, 10);
        drive_n(1'b0, 1'b1, 10, 14);
        drive(1'b1, 1'b1, 10);
        drive_n(1'b0, 1'b1, 10, 10);

        // Randomised enables, crush changes (occasionally huge) and sporadic resets.
        cur_c = 3;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 3) == 0) cur_c = int'($urandom_range(0, 131071));
                else cur_c = int'($urandom_range(0, 12));
            end
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 3) != 0);
            drive(r, e, cur_c);
        end

        // Long free run at full rate exercises a long stretch of the sequence.
        drive(1'b1, 1'b0, 1);
        drive_n(1'b0, 1'b1, 1, 20000);
        drive_n(1'b0, 1'b1, 0, 5000);

        // Let the monitor drain, then confirm every prediction was consumed.
        repeat (3) @(posedge clk);
        #3;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
